// File: rtl/data_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_sram_responder: fixed-latency in-order SRAM slave with request FIFO |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module data_sram_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int QDEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      data_sram_req,
  input  logic                      data_sram_wr,
  input  logic [1:0]                data_sram_size,
  input  logic [3:0]                data_sram_wstrb,
  input  logic [31:0]               data_sram_addr,
  input  logic [31:0]               data_sram_wdata,
  output logic                      data_sram_addr_ok,
  output logic                      data_sram_data_ok,
  output logic [31:0]               data_sram_rdata,
  output logic [$clog2(QDEPTH):0]   outstanding
);

  localparam int             c_iw   = $clog2(MEM_WORDS);
  localparam int             c_pw   = $clog2(QDEPTH);
  localparam logic [2:0]     c_lat  = LATENCY[2:0];
  localparam logic [c_pw:0]  c_full = QDEPTH[c_pw:0];

  logic [31:0]      r_mem    [MEM_WORDS];
  logic             r_q_wr   [QDEPTH];
  logic [3:0]       r_q_strb [QDEPTH];
  logic [c_iw-1:0]  r_q_idx  [QDEPTH];
  logic [31:0]      r_q_data [QDEPTH];
  logic [2:0]       r_q_age  [QDEPTH];
  logic [c_pw-1:0]  r_rptr;
  logic [c_pw-1:0]  r_wptr;
  logic [c_pw:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_unused;

  // Full blocks acceptance even when the head pops in the same cycle.
  assign w_push = resetn & data_sram_req & (r_count != c_full);
  assign w_pop  = resetn & (r_count != '0) & (r_q_age[r_rptr] == c_lat);

  assign data_sram_addr_ok = w_push;
  assign data_sram_data_ok = w_pop;
  assign data_sram_rdata   = (w_pop && !r_q_wr[r_rptr]) ? r_mem[r_q_idx[r_rptr]] : 32'h0;
  assign outstanding       = resetn ? r_count : '0;

  assign w_unused = ^{data_sram_size, data_sram_addr[31:c_iw+2], data_sram_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) r_q_age[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (r_q_age[i] != c_lat) r_q_age[i] <= r_q_age[i] + 3'd1;
      end
      if (w_push) begin
        r_q_age[r_wptr] <= '0;
        r_wptr          <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_wr[r_wptr]   <= data_sram_wr;
      r_q_strb[r_wptr] <= data_sram_wstrb;
      r_q_idx[r_wptr]  <= data_sram_addr[c_iw+1:2];
      r_q_data[r_wptr] <= data_sram_wdata;
    end
  end

  // Memory is deliberately not reset; only the head write commits, at its pop edge.
  always_ff @(posedge clk) begin
    if (w_pop && r_q_wr[r_rptr]) begin
      for (int b = 0; b < 4; b++) begin
        if (r_q_strb[r_rptr][b]) r_mem[r_q_idx[r_rptr]][8*b +: 8] <= r_q_data[r_rptr][8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_sram_responder: directed + random bench with queue-based model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_data_sram_responder;

  localparam int MW  = 1024;
  localparam int LAT = 2;
  localparam int QD  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0, wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [2:0]  outstanding;

  logic        req4 = 1'b0;
  logic        wr4 = 1'b0;
  logic [1:0]  size4 = 2'd2;
  logic [3:0]  wstrb4 = 4'h0;
  logic [31:0] addr4 = 32'h0, wdata4 = 32'h0;
  logic        aok4, dok4;
  logic [31:0] rdata4;
  logic [2:0]  out4;

  data_sram_responder dut (
    .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .outstanding(outstanding)
  );

  data_sram_responder #(.MEM_WORDS(64), .LATENCY(4), .QDEPTH(4)) dut4 (
    .clk(clk), .resetn(resetn), .data_sram_req(req4), .data_sram_wr(wr4),
    .data_sram_size(size4), .data_sram_wstrb(wstrb4), .data_sram_addr(addr4),
    .data_sram_wdata(wdata4), .data_sram_addr_ok(aok4), .data_sram_data_ok(dok4),
    .data_sram_rdata(rdata4), .outstanding(out4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [3:0]  strb;
    logic [9:0]  idx;
    logic [31:0] data;
    int          t;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mmem [MW];
  int          cycle = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] got[$];
  int          got_cyc[$];
  logic        o4_aok, o4_dok;
  logic [2:0]  o4_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a request accepted at the end of cycle c answers in the first cycle
  // >= c+1+LAT in which it is at the head; answers leave in acceptance order.
  task automatic model_step();
    logic        e_aok, e_dok;
    logic [31:0] e_rd;
    int          e_out;
    ent_t        h, n;
    if (!resetn) begin
      e_aok = 1'b0; e_dok = 1'b0; e_rd = 32'h0; e_out = 0;
    end else begin
      e_out = mq.size();
      e_aok = req && (mq.size() != QD);
      e_dok = (mq.size() > 0) && (cycle - mq[0].t >= LAT);
      e_rd  = (e_dok && !mq[0].wr) ? mmem[mq[0].idx] : 32'h0;
    end
    chk("addr_ok", 32'(addr_ok), 32'(e_aok));
    chk("data_ok", 32'(data_ok), 32'(e_dok));
    chk("rdata", rdata, e_rd);
    chk("outstanding", 32'(outstanding), 32'(e_out));
    if (data_ok) begin
      got.push_back(rdata);
      got_cyc.push_back(cycle);
    end
    if (!resetn) begin
      mq.delete();
    end else begin
      if (e_dok) begin
        h = mq.pop_front();
        if (h.wr) begin
          for (int b = 0; b < 4; b++)
            if (h.strb[b]) mmem[h.idx][8*b +: 8] = h.data[8*b +: 8];
        end
      end
      if (e_aok) begin
        n.wr = wr; n.strb = wstrb; n.idx = addr[11:2]; n.data = wdata; n.t = cycle + 1;
        mq.push_back(n);
      end
    end
    o4_aok = aok4; o4_dok = dok4; o4_out = out4;
    cycle++;
  endtask

  task automatic cyc(input logic rq, input logic w, input logic [3:0] st,
                     input logic [31:0] a, input logic [31:0] d);
    req = rq; wr = w; wstrb = st; addr = a; wdata = d; size = 2'd2;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && mq.size() > 0; k++) idle(1);
    idle(1);
    chk("drain_outstanding", 32'(outstanding), 32'h0);
  endtask

  task automatic clr();
    got.delete();
    got_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0, n_dok;
    logic [31:0] d, o[3];
    logic        t_aok[7] = '{1, 1, 1, 1, 0, 0, 1};
    logic        t_dok[7] = '{0, 0, 0, 0, 0, 1, 1};
    int          t_out[7] = '{0, 1, 2, 3, 4, 4, 3};

    @(posedge clk); #1;
    resetn = 1'b0;
    idle(3);
    resetn = 1'b1;

    // Fill every word (first cycle after reset must accept); doubles as a write stream.
    for (int i = 0; i < MW; i++)
      cyc(1'b1, 1'b1, 4'hF, ($urandom & 32'hFFFF_F000) | 32'(i * 4), $urandom);
    drain();

    clr();
    c0 = cycle;
    cyc(1'b1, 1'b1, 4'hF, 32'h10, 32'hA5A5_A5A5);
    drain();
    chk("write_latency", 32'(got_cyc[0]), 32'(c0 + 1 + LAT));
    clr();
    cyc(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    drain();
    chk("read_0x10", got[0], 32'hA5A5_A5A5);

    clr();
    cyc(1'b1, 1'b1, 4'hF, 32'h20, 32'h1122_3344);
    cyc(1'b1, 1'b1, 4'b0100, 32'h20, 32'hEEEE_EEEE);
    cyc(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    drain();
    chk("byte_merge", got[2], 32'h11EE_3344);

    clr();
    d = $urandom;
    cyc(1'b1, 1'b1, 4'hF, 32'h0, d);
    cyc(1'b1, 1'b0, 4'h0, 32'(MW * 4), 32'h0);
    drain();
    chk("alias_raw", got[1], d);

    clr();
    d = 32'h5A5A_0F0F;
    cyc(1'b1, 1'b1, 4'hF, 32'h30, d);
    cyc(1'b1, 1'b1, 4'h0, 32'h30, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
    drain();
    chk("wstrb0_count", 32'(got.size()), 32'd3);
    chk("wstrb0_data", got[2], d);

    clr();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 4'h0, 32'h100 + 32'(i * 4), 32'h0);
    drain();
    chk("stream_count", 32'(got.size()), 32'd8);
    chk("stream_span", 32'(got_cyc[7] - got_cyc[0]), 32'd7);

    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), 4'($urandom),
          $urandom, $urandom);
    drain();

    // Reset while three writes are queued: none may commit.
    d = 32'hC0DE_0000;
    o[0] = 32'h0BAD_0001; o[1] = 32'h0BAD_0002; o[2] = 32'h0BAD_0003;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'hF, 32'h40 + 32'(i * 4), o[i]);
    drain();
    clr();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'hF, 32'h40 + 32'(i * 4), d + 32'(i));
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    chk("rst_no_data_ok", 32'(got.size()), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'h0, 32'h40 + 32'(i * 4), 32'h0);
    drain();
    for (int i = 0; i < 3; i++) chk($sformatf("rst_keep_%0d", i), got[i], o[i]);

    // Full-queue stall on the LATENCY=4 instance with the request held high.
    req4 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      idle(1);
      chk($sformatf("stall_aok_%0d", i), 32'(o4_aok), 32'(t_aok[i]));
      chk($sformatf("stall_dok_%0d", i), 32'(o4_dok), 32'(t_dok[i]));
      chk($sformatf("stall_out_%0d", i), 32'(o4_out), 32'(t_out[i]));
    end
    req4 = 1'b0;
    n_dok = 2;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      n_dok += int'(o4_dok);
    end
    chk("stall_total_dok", 32'(n_dok), 32'd5);
    chk("stall_out_end", 32'(o4_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning backing-store depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning minimum cycles from request acceptance to response (legal 1..7).
REQ-003 SHALL have parameter QDEPTH, default 4, meaning maximum outstanding requests (power of two, at least 2).
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port data_sram_req  in  1  request valid from the initiator.
REQ-007 SHALL have port data_sram_wr  in  1  1=write, 0=read.
REQ-008 SHALL have port data_sram_size  in  2  0=byte, 1=half, 2=word (informational; wstrb governs writes).
REQ-009 SHALL have port data_sram_wstrb  in  4  byte-lane write enables.
REQ-010 SHALL have port data_sram_addr  in  32  byte address.
REQ-011 SHALL have port data_sram_wdata  in  32  write data, lane-replicated by the initiator.
REQ-012 SHALL have port data_sram_addr_ok  out  1  request accepted this cycle.
REQ-013 SHALL have port data_sram_data_ok  out  1  response valid this cycle.
REQ-014 SHALL have port data_sram_rdata  out  32  read data, valid with data_ok for reads.
REQ-015 SHALL have port outstanding  out  $clog2(QDEPTH)+1  number of queued, unanswered requests.

Function
REQ-016 SHALL assert addr_ok = req & (outstanding != QDEPTH); acceptance = req & addr_ok at a rising edge.
REQ-017 SHALL NOT let a same-cycle pop free a slot for acceptance: full means no addr_ok, even when data_ok is asserted.
REQ-018 SHALL capture {wr, wstrb, word index, wdata} of each accepted request into a circular FIFO of QDEPTH entries with wrapping read/write pointers.
REQ-019 SHALL form the word index from addr[$clog2(MEM_WORDS)+1:2]; higher address bits are ignored, so addresses alias modulo MEM_WORDS*4.
REQ-020 SHALL give each entry a 3-bit age counter, zeroed on enqueue, incremented every cycle, saturating at LATENCY.
REQ-021 SHALL assert data_ok in a cycle iff the FIFO is non-empty and the head age equals LATENCY; the head is popped at that edge.
REQ-022 SHALL respond strictly in acceptance order, at most one response per cycle; a request accepted at edge N responds no earlier than cycle N+LATENCY.
REQ-023 SHALL sustain throughput of one response per cycle for back-to-back accepted requests.
REQ-024 SHALL drive rdata, for a read response, with the full memory word at the head index as of that cycle (combinational read), else 32'h0.
REQ-025 SHALL commit a write at the edge ending its data_ok cycle, updating only byte lanes with wstrb set; wstrb=4'b0000 SHALL still produce data_ok and leave memory unchanged.
REQ-026 SHALL guarantee read-after-write ordering: a read queued behind a write to the same word returns the merged data.
REQ-027 SHALL update outstanding as +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
REQ-028 SHALL ignore wr/size/wstrb/addr/wdata while req=0 or addr_ok=0.

Reset
REQ-029 SHALL, while resetn=0, hold addr_ok=0, data_ok=0, rdata=0, outstanding=0, and clear pointers and ages.
REQ-030 SHALL, on reset mid-operation, discard all queued requests without committing pending writes; memory contents SHALL be retained (not reset).
REQ-031 SHALL accept a new request in the first cycle after resetn returns high.

Verification
REQ-032 SHALL pass single write then read: write addr 0x10, wdata 0xA5A5A5A5, wstrb 4'hF accepted at edge N -> data_ok in cycle N+2; read 0x10 -> rdata 0xA5A5A5A5.
REQ-033 SHALL pass byte merge: word 0x20 = 0x11223344, then write wstrb 4'b0100, wdata 0xEEEEEEEE -> read returns 0x11EE3344.
REQ-034 SHALL pass full-queue stall: 5 back-to-back reads with QDEPTH=4 -> addr_ok low on the 5th until the first data_ok pops; outstanding peaks at 4.
REQ-035 SHALL pass streaming: 8 consecutive accepted reads with LATENCY=2 -> 8 data_ok pulses in 8 consecutive cycles, in order.
REQ-036 SHALL pass alias and RAW: write 0x0 then read (MEM_WORDS*4) back-to-back -> read returns the written data.
REQ-037 SHALL pass reset mid-flight: 3 writes queued, resetn low for 1 cycle -> no data_ok, outstanding=0, target words unchanged.
